// File: rtl/mcu_spi_pkg.sv
// Shared opcodes, frame geometry, FSM states and the STATUS word layout for the
// MCU-facing SPI responder that drains Goertzel magnitudes.
package mcu_spi_pkg;

   localparam int CMD_BITS   = 8;
   localparam int RESP_BITS  = 16;
   localparam int FRAME_BITS = CMD_BITS + RESP_BITS;

   localparam logic [7:0] CMD_POP    = 8'h01;
   localparam logic [7:0] CMD_PEEK   = 8'h02;
   localparam logic [7:0] CMD_STATUS = 8'h03;
   localparam logic [7:0] CMD_CLEAR  = 8'h04;

   localparam int ST_OVERRUN_BIT = 15;
   localparam int ST_EMPTY_BIT   = 14;
   localparam int ST_FULL_BIT    = 13;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      RESP,
      DONE
   } state_e;

   function automatic logic [RESP_BITS-1:0] status_word(input logic       ov,
                                                        input logic       empty,
                                                        input logic       full,
                                                        input logic [7:0] count);
      logic [RESP_BITS-1:0] w;
      w                 = {8'h00, count};
      w[ST_OVERRUN_BIT] = ov;
      w[ST_EMPTY_BIT]   = empty;
      w[ST_FULL_BIT]    = full;
      return w;
   endfunction

endpackage

// File: rtl/mag_fifo.sv
// Single-clock FIFO for magnitude results; pointers carry one extra wrap bit so
// full and empty are told apart by the pointer difference alone.
module mag_fifo #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [DATA_W-1:0]      push_data_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   output logic [DATA_W-1:0]      head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              do_push;
   logic              do_pop;

   assign count_o = wr_ptr_q - rd_ptr_q;
   assign empty_o = (count_o == '0);
   assign full_o  = (count_o == (AW+1)'(DEPTH));
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // A pop frees the slot a full-FIFO push writes into, so both may proceed.
   assign do_push = push_i & ~flush_i & (~full_o | pop_i);
   assign do_pop  = pop_i & ~flush_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = flush_i ? wr_ptr_q : rd_ptr_q + (AW+1)'(do_pop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage has no reset; entries are only visible once written.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/mcu_spi_responder.sv
// Mode-0 SPI responder: synchronises the MCU pins into sys_clk, decodes an 8-bit
// command, shifts a 16-bit response and commits side effects on the 24th rise.
module mcu_spi_responder
   import mcu_spi_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 16
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              mag_valid,
   input  logic [DATA_W-1:0] mag_data,
   input  logic              spi_csn,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              irq,
   output logic              overrun
);

   localparam int CNT_W = $clog2(FRAME_BITS);

   // Pipe index 0 = first flop, 1 = synchronised value, 2 = edge-detect history.
   logic [2:0] csn_pipe_q, sck_pipe_q, mosi_pipe_q;
   logic       csn_fall, csn_rise, sck_rise, sck_fall, mosi_bit;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [CMD_BITS-2:0]   cmd_sr_q, cmd_sr_d;
   logic [RESP_BITS-1:0]  resp_sr_q, resp_sr_d;
   logic [7:0]            cmd_q, cmd_d;
   logic                  pop_ok_q, pop_ok_d;
   logic                  miso_q, miso_d;
   logic                  oe_q;
   logic                  overrun_q, overrun_d;
   logic                  commit;
   logic [7:0]            cmd_word;
   logic [RESP_BITS-1:0]  resp_load;

   logic [DATA_W-1:0]      fifo_head;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   fifo_full, fifo_empty, fifo_pop, fifo_flush, ov_clear;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         csn_pipe_q  <= 3'b111;
         sck_pipe_q  <= 3'b000;
         mosi_pipe_q <= 3'b000;
      end else begin
         csn_pipe_q  <= {csn_pipe_q[1:0], spi_csn};
         sck_pipe_q  <= {sck_pipe_q[1:0], spi_sck};
         mosi_pipe_q <= {mosi_pipe_q[1:0], spi_mosi};
      end
   end

   assign csn_fall = csn_pipe_q[2] & ~csn_pipe_q[1];
   assign csn_rise = ~csn_pipe_q[2] & csn_pipe_q[1];
   assign sck_rise = ~sck_pipe_q[2] & sck_pipe_q[1];
   assign sck_fall = sck_pipe_q[2] & ~sck_pipe_q[1];
   assign mosi_bit = mosi_pipe_q[2];
   assign cmd_word = {cmd_sr_q, mosi_bit};

   always_comb begin
      resp_load = '0;
      case (cmd_word)
         CMD_POP, CMD_PEEK: resp_load = fifo_empty ? '0 : RESP_BITS'(fifo_head);
         CMD_STATUS:        resp_load = status_word(overrun_q, fifo_empty, fifo_full,
                                                    8'(fifo_count));
         default:           resp_load = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      cmd_sr_d  = cmd_sr_q;
      resp_sr_d = resp_sr_q;
      cmd_d     = cmd_q;
      pop_ok_d  = pop_ok_q;
      miso_d    = miso_q;
      commit    = 1'b0;
      if (csn_rise) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         miso_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (csn_fall) begin
                  state_d   = CMD;
                  bit_cnt_d = '0;
                  miso_d    = 1'b0;
               end
            end
            CMD: begin
               if (sck_rise) begin
                  cmd_sr_d  = {cmd_sr_q[CMD_BITS-3:0], mosi_bit};
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                     cmd_d     = cmd_word;
                     // Latched so a POP that saw an empty FIFO never pops a later arrival.
                     pop_ok_d  = ~fifo_empty;
                     resp_sr_d = resp_load;
                     state_d   = RESP;
                  end
               end
            end
            RESP: begin
               if (sck_fall) begin
                  miso_d    = resp_sr_q[RESP_BITS-1];
                  resp_sr_d = {resp_sr_q[RESP_BITS-2:0], 1'b0};
               end else if (sck_rise) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                     commit  = 1'b1;
                     state_d = DONE;
                     miso_d  = 1'b0;
                  end
               end
            end
            DONE:    miso_d = 1'b0;
            default: state_d = IDLE;
         endcase
      end
   end

   assign fifo_pop   = commit & (cmd_q == CMD_POP) & pop_ok_q;
   assign fifo_flush = commit & (cmd_q == CMD_CLEAR);
   assign ov_clear   = commit & ((cmd_q == CMD_STATUS) | (cmd_q == CMD_CLEAR));

   always_comb begin
      overrun_d = ov_clear ? 1'b0 : overrun_q;
      if (mag_valid & fifo_full & ~fifo_pop & ~fifo_flush) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         cmd_sr_q  <= '0;
         resp_sr_q <= '0;
         cmd_q     <= '0;
         pop_ok_q  <= 1'b0;
         miso_q    <= 1'b0;
         oe_q      <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         cmd_sr_q  <= cmd_sr_d;
         resp_sr_q <= resp_sr_d;
         cmd_q     <= cmd_d;
         pop_ok_q  <= pop_ok_d;
         miso_q    <= miso_d;
         oe_q      <= ~csn_pipe_q[1];
         overrun_q <= overrun_d;
      end
   end

   mag_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk_i       (sys_clk),
      .rst_i       (rst),
      .push_i      (mag_valid),
      .push_data_i (mag_data),
      .pop_i       (fifo_pop),
      .flush_i     (fifo_flush),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign spi_miso    = miso_q;
   assign spi_miso_oe = oe_q;
   assign irq         = ~fifo_empty;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_mcu_spi_responder.sv
// Scoreboard bench: a queue-based model predicts each frame's response, and a pin
// monitor reassembles MISO words and compares them against the expected queue.
module tb_mcu_spi_responder;
   import mcu_spi_pkg::*;

   localparam int DEPTH = 8;
   localparam int HALF  = 6;

   logic        sys_clk   = 1'b0;
   logic        rst       = 1'b1;
   logic        mag_valid = 1'b0;
   logic [15:0] mag_data  = '0;
   logic        spi_csn   = 1'b1;
   logic        spi_sck   = 1'b0;
   logic        spi_mosi  = 1'b0;
   logic        spi_miso, spi_miso_oe, irq, overrun;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [15:0] exp_q[$];
   logic [15:0] model_q[$];
   logic        model_ov = 1'b0;

   always #5 sys_clk = ~sys_clk;

   mcu_spi_responder #(.DEPTH(DEPTH), .DATA_W(16)) dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .mag_valid   (mag_valid),
      .mag_data    (mag_data),
      .spi_csn     (spi_csn),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .irq         (irq),
      .overrun     (overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [15:0] model_resp(input logic [7:0] cmd);
      int n;
      logic [15:0] r;
      n = model_q.size();
      r = 16'h0000;
      if (cmd == 8'h01 || cmd == 8'h02) begin
         if (n > 0) r = model_q[0];
      end else if (cmd == 8'h03) begin
         r[15]  = model_ov;
         r[14]  = (n == 0);
         r[13]  = (n == DEPTH);
         r[7:0] = 8'(n);
      end
      return r;
   endfunction

   task automatic model_push(input logic [15:0] d);
      if (model_q.size() < DEPTH) model_q.push_back(d);
      else model_ov = 1'b1;
   endtask

   task automatic model_commit(input logic [7:0] cmd);
      if (cmd == 8'h01) begin
         if (model_q.size() > 0) void'(model_q.pop_front());
      end else if (cmd == 8'h03) begin
         model_ov = 1'b0;
      end else if (cmd == 8'h04) begin
         model_q.delete();
         model_ov = 1'b0;
      end
   endtask

   task automatic push_val(input logic [15:0] d);
      @(negedge sys_clk);
      mag_valid = 1'b1;
      mag_data  = d;
      @(negedge sys_clk);
      mag_valid = 1'b0;
      model_push(d);
      check("irq_after_push", irq, model_q.size() != 0);
      check("overrun_after_push", overrun, model_ov);
   endtask

   // abort_at > 0 raises CSN after that many SCK rises; co_push strobes mag_valid
   // in the very cycle the 24th rise is acted upon.
   task automatic run_frame(input logic [7:0] cmd, input int abort_at,
                            input bit co_push, input logic [15:0] co_data);
      if (abort_at == 0) exp_q.push_back(model_resp(cmd));
      @(negedge sys_clk);
      spi_csn = 1'b0;
      repeat (6) @(negedge sys_clk);
      for (int i = 0; i < FRAME_BITS; i++) begin
         if (abort_at != 0 && i == abort_at) break;
         spi_mosi = (i < CMD_BITS) ? cmd[7-i] : 1'b0;
         repeat (HALF) @(negedge sys_clk);
         if (i == 2) check("miso_oe_active", spi_miso_oe, 1'b1);
         spi_sck = 1'b1;
         if (i == FRAME_BITS - 1) begin
            repeat (2) @(negedge sys_clk);
            check("irq_pre_commit", irq, model_q.size() != 0);
            check("overrun_pre_commit", overrun, model_ov);
            if (co_push) begin
               mag_valid = 1'b1;
               mag_data  = co_data;
            end
            @(posedge sys_clk);
            #1;
            model_commit(cmd);
            if (co_push && cmd != 8'h04) model_push(co_data);
            check("irq_post_commit", irq, model_q.size() != 0);
            check("overrun_post_commit", overrun, model_ov);
            @(negedge sys_clk);
            mag_valid = 1'b0;
            repeat (HALF - 3) @(negedge sys_clk);
         end else begin
            repeat (HALF) @(negedge sys_clk);
         end
         spi_sck = 1'b0;
      end
      repeat (HALF) @(negedge sys_clk);
      if (abort_at == 0) check("miso_done_low", spi_miso, 1'b0);
      spi_csn  = 1'b1;
      spi_mosi = 1'b0;
      repeat (8) @(negedge sys_clk);
      check("miso_oe_idle", spi_miso_oe, 1'b0);
      check("miso_idle", spi_miso, 1'b0);
   endtask

   // Monitor: rebuild the response word from MISO at each SCK rise while CSN is low.
   initial begin
      int          nbits;
      logic [15:0] word;
      nbits = 0;
      word  = '0;
      forever begin
         @(posedge spi_sck or posedge spi_csn);
         if (spi_csn) begin
            if (nbits == FRAME_BITS) begin
               if (exp_q.size() == 0) check("resp_unexpected", exp_q.size(), 1);
               else check("frame_resp", word, exp_q.pop_front());
            end
            nbits = 0;
            word  = '0;
         end else begin
            if (nbits >= CMD_BITS && nbits < FRAME_BITS) word = {word[14:0], spi_miso};
            nbits++;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] first_val;
      logic [7:0]  cmd_tbl [5];

      repeat (3) @(negedge sys_clk);
      check("rst_miso", spi_miso, 1'b0);
      check("rst_miso_oe", spi_miso_oe, 1'b0);
      check("rst_irq", irq, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      rst = 1'b0;
      repeat (4) @(negedge sys_clk);
      check("idle_irq", irq, 1'b0);

      push_val(16'h1234);
      push_val(16'hBEEF);
      run_frame(CMD_POP, 0, 1'b0, 16'h0);
      run_frame(CMD_POP, 0, 1'b0, 16'h0);

      first_val = 16'hA000;
      for (int i = 0; i < DEPTH + 1; i++) push_val(first_val + 16'(i));
      run_frame(CMD_STATUS, 0, 1'b0, 16'h0);
      run_frame(CMD_POP, 0, 1'b0, 16'h0);
      run_frame(CMD_CLEAR, 0, 1'b0, 16'h0);
      run_frame(CMD_STATUS, 0, 1'b0, 16'h0);

      push_val(16'h00AA);
      run_frame(CMD_PEEK, 0, 1'b0, 16'h0);
      run_frame(CMD_PEEK, 0, 1'b0, 16'h0);
      run_frame(CMD_STATUS, 0, 1'b0, 16'h0);
      run_frame(CMD_POP, 0, 1'b0, 16'h0);
      run_frame(CMD_POP, 0, 1'b0, 16'h0);
      run_frame(CMD_STATUS, 0, 1'b0, 16'h0);

      for (int i = 0; i < 3; i++) push_val(16'h3000 + 16'(i));
      run_frame(CMD_POP, 12, 1'b0, 16'h0);
      run_frame(CMD_STATUS, 0, 1'b0, 16'h0);

      for (int i = 0; i < 5; i++) push_val(16'h5000 + 16'(i));
      run_frame(CMD_POP, 0, 1'b1, 16'h7777);
      run_frame(CMD_STATUS, 0, 1'b0, 16'h0);
      run_frame(CMD_POP, 0, 1'b0, 16'h0);

      @(negedge sys_clk);
      spi_csn = 1'b0;
      repeat (6) @(negedge sys_clk);
      for (int i = 0; i < 16; i++) begin
         spi_mosi = (i < CMD_BITS) ? CMD_STATUS[7-i] : 1'b0;
         repeat (HALF) @(negedge sys_clk);
         spi_sck = 1'b1;
         repeat (HALF) @(negedge sys_clk);
         spi_sck = 1'b0;
      end
      rst = 1'b1;
      #2;
      check("midrst_miso", spi_miso, 1'b0);
      check("midrst_miso_oe", spi_miso_oe, 1'b0);
      check("midrst_irq", irq, 1'b0);
      check("midrst_overrun", overrun, 1'b0);
      @(negedge sys_clk);
      spi_csn  = 1'b1;
      spi_mosi = 1'b0;
      repeat (4) @(negedge sys_clk);
      rst = 1'b0;
      model_q.delete();
      model_ov = 1'b0;
      repeat (4) @(negedge sys_clk);
      check("post_rst_irq", irq, 1'b0);
      run_frame(CMD_STATUS, 0, 1'b0, 16'h0);

      cmd_tbl[0] = CMD_POP;
      cmd_tbl[1] = CMD_PEEK;
      cmd_tbl[2] = CMD_STATUS;
      cmd_tbl[3] = CMD_CLEAR;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            int n;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) push_val(16'($urandom()));
         end else begin
            logic [7:0] c;
            int         ab;
            cmd_tbl[4] = 8'($urandom());
            c  = cmd_tbl[$urandom_range(0, 4)];
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 23) : 0;
            run_frame(c, ab, 1'($urandom_range(0, 3) == 0), 16'($urandom()));
         end
      end
      run_frame(CMD_STATUS, 0, 1'b0, 16'h0);

      repeat (10) @(negedge sys_clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
